// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Drives ALU operands/opcode plus store data and writeback control to the next stage.
module ex_operand_stage #(
  parameter int unsigned n  = 32,
  parameter int unsigned RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [n-1:0]  id_pc,
  input  logic [RA-1:0] id_rs1_addr,
  input  logic [RA-1:0] id_rs2_addr,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [n-1:0]  id_rs1_data,
  input  logic [n-1:0]  id_rs2_data,
  input  logic [n-1:0]  id_imm,
  input  logic [3:0]    id_alu_control,
  input  logic          id_alu_src_a,
  input  logic          id_alu_src_b,
  input  logic [RA-1:0] id_rd_addr,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic          ext_stall,
  input  logic [RA-1:0] exmem_rd_addr,
  input  logic          exmem_reg_write,
  input  logic [n-1:0]  exmem_result,
  input  logic [RA-1:0] memwb_rd_addr,
  input  logic          memwb_reg_write,
  input  logic [n-1:0]  memwb_result,
  output logic [n-1:0]  alu_a,
  output logic [n-1:0]  alu_b,
  output logic [3:0]    alu_control,
  output logic          ex_valid,
  output logic [n-1:0]  ex_store_data,
  output logic [RA-1:0] ex_rd_addr,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          load_use_stall
);

  logic          valid_q, valid_d;
  logic [n-1:0]  pc_q, pc_d;
  logic [n-1:0]  imm_q, imm_d;
  logic [n-1:0]  rs1_data_q, rs1_data_d;
  logic [n-1:0]  rs2_data_q, rs2_data_d;
  logic [RA-1:0] rs1_addr_q, rs1_addr_d;
  logic [RA-1:0] rs2_addr_q, rs2_addr_d;
  logic [RA-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]    alu_control_q, alu_control_d;
  logic          src_a_q, src_a_d;
  logic          src_b_q, src_b_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic [n-1:0]  fwd_rs1, fwd_rs2;
  logic          rs1_hit, rs2_hit;

  // x0 is hard-wired zero, so a write targeting it is never a forwarding source.
  function automatic logic [n-1:0] fwd_sel(
    input logic [RA-1:0] addr,
    input logic [n-1:0]  rf_data,
    input logic          em_we,
    input logic [RA-1:0] em_rd,
    input logic [n-1:0]  em_res,
    input logic          mw_we,
    input logic [RA-1:0] mw_rd,
    input logic [n-1:0]  mw_res
  );
    if (em_we && (em_rd != '0) && (em_rd == addr)) begin
      return em_res;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == addr)) begin
      return mw_res;
    end
    return rf_data;
  endfunction

  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1_addr == rd_addr_q);
    rs2_hit = id_rs2_used && (id_rs2_addr == rd_addr_q);
    load_use_stall = id_valid && valid_q && mem_read_q && (rd_addr_q != '0) &&
                     (rs1_hit || rs2_hit);
    id_ready = !load_use_stall && !ext_stall;
  end

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rd_addr_d     = rd_addr_q;
    alu_control_d = alu_control_q;
    src_a_d       = src_a_q;
    src_b_d       = src_b_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    if (flush || (!ext_stall && load_use_stall)) begin
      valid_d       = 1'b0;
      pc_d          = '0;
      imm_d         = '0;
      rs1_data_d    = '0;
      rs2_data_d    = '0;
      rs1_addr_d    = '0;
      rs2_addr_d    = '0;
      rd_addr_d     = '0;
      alu_control_d = '0;
      src_a_d       = 1'b0;
      src_b_d       = 1'b0;
      reg_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_write_d   = 1'b0;
    end else if (!ext_stall) begin
      valid_d       = id_valid;
      pc_d          = id_pc;
      imm_d         = id_imm;
      rs1_data_d    = id_rs1_data;
      rs2_data_d    = id_rs2_data;
      rs1_addr_d    = id_rs1_addr;
      rs2_addr_d    = id_rs2_addr;
      rd_addr_d     = id_rd_addr;
      src_a_d       = id_alu_src_a;
      src_b_d       = id_alu_src_b;
      // An empty slot behaves as a bubble: no opcode, no side effects.
      alu_control_d = id_valid ? id_alu_control : 4'b0000;
      reg_write_d   = id_valid && id_reg_write;
      mem_read_d    = id_valid && id_mem_read;
      mem_write_d   = id_valid && id_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_addr_q     <= '0;
      alu_control_q <= '0;
      src_a_q       <= 1'b0;
      src_b_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_addr_q     <= rd_addr_d;
      alu_control_q <= alu_control_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  always_comb begin
    fwd_rs1 = fwd_sel(rs1_addr_q, rs1_data_q, exmem_reg_write, exmem_rd_addr, exmem_result,
                      memwb_reg_write, memwb_rd_addr, memwb_result);
    fwd_rs2 = fwd_sel(rs2_addr_q, rs2_data_q, exmem_reg_write, exmem_rd_addr, exmem_result,
                      memwb_reg_write, memwb_rd_addr, memwb_result);
    alu_a         = src_a_q ? pc_q : fwd_rs1;
    alu_b         = src_b_q ? imm_q : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

  assign alu_control  = alu_control_q;
  assign ex_valid     = valid_q;
  assign ex_rd_addr   = rd_addr_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed literal cases, then random traffic vs a
// instruction-level model of what sits in EX.
module tb_ex_operand_stage;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;

  logic        clk, rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rs1_used, id_rs2_used;
  logic [3:0]  id_alu_control;
  logic        id_alu_src_a, id_alu_src_b;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ext_stall;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic        ex_valid;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.n(32), .RA(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_control(id_alu_control), .id_alu_src_a(id_alu_src_a),
    .id_alu_src_b(id_alu_src_b), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .ext_stall(ext_stall),
    .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result),
    .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_valid(ex_valid),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_stall(load_use_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The instruction currently held in EX, as the model sees it.
  typedef struct {
    bit        v;
    bit [31:0] pc, imm, d1, d2;
    bit [4:0]  a1, a2, rd;
    bit [3:0]  op;
    bit        sa, sb, rw, mr, mw;
  } ex_t;

  ex_t m, mn;
  bit  exp_lu, exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_alu_control = 0; id_alu_src_a = 0; id_alu_src_b = 0; id_rd_addr = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    flush = 0; ext_stall = 0;
    exmem_rd_addr = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd_addr = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] model_fwd(input bit [4:0] addr, input bit [31:0] rf);
    if (exmem_reg_write && exmem_rd_addr != 0 && exmem_rd_addr == addr) return exmem_result;
    if (memwb_reg_write && memwb_rd_addr != 0 && memwb_rd_addr == addr) return memwb_result;
    return rf;
  endfunction

  task automatic gen_id();
    id_valid       = ($urandom_range(0, 3) != 0);
    id_pc          = $urandom;
    id_rs1_addr    = 5'($urandom_range(0, 3));
    id_rs2_addr    = 5'($urandom_range(0, 3));
    id_rs1_used    = 1'($urandom_range(0, 1));
    id_rs2_used    = 1'($urandom_range(0, 1));
    id_rs1_data    = $urandom;
    id_rs2_data    = $urandom;
    id_imm         = $urandom;
    id_alu_src_a   = 1'($urandom_range(0, 1));
    id_alu_src_b   = 1'($urandom_range(0, 1));
    id_rd_addr     = 5'($urandom_range(0, 3));
    id_alu_control = id_valid ? 4'($urandom_range(1, 15)) : 4'd0;
    id_reg_write   = id_valid && ($urandom_range(0, 1) == 1);
    id_mem_read    = id_valid && ($urandom_range(0, 2) == 0);
    id_mem_write   = id_valid && ($urandom_range(0, 3) == 0);
  endtask

  task automatic check_model();
    bit [31:0] f1, f2;
    exp_lu = id_valid && m.v && m.mr && m.rd != 0 &&
             ((id_rs1_used && id_rs1_addr == m.rd) || (id_rs2_used && id_rs2_addr == m.rd));
    exp_ready = !exp_lu && !ext_stall;
    chk("rand_ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
    chk("rand_load_use", {31'd0, load_use_stall}, {31'd0, exp_lu});
    chk("rand_id_ready", {31'd0, id_ready}, {31'd0, exp_ready});
    chk("rand_alu_control", {28'd0, alu_control}, {28'd0, m.v ? m.op : 4'd0});
    chk("rand_enables", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
        m.v ? {29'd0, m.rw, m.mr, m.mw} : 32'd0);
    if (m.v) begin
      f1 = model_fwd(m.a1, m.d1);
      f2 = model_fwd(m.a2, m.d2);
      chk("rand_alu_a", alu_a, m.sa ? m.pc : f1);
      chk("rand_alu_b", alu_b, m.sb ? m.imm : f2);
      chk("rand_store_data", ex_store_data, f2);
      chk("rand_rd_addr", {27'd0, ex_rd_addr}, {27'd0, m.rd});
    end
    // Next EX contents by the stage's priority rules.
    if (flush || (!ext_stall && exp_lu)) begin
      mn = '{default: 0};
    end else if (ext_stall) begin
      mn = m;
    end else begin
      mn.v = id_valid; mn.pc = id_pc; mn.imm = id_imm;
      mn.d1 = id_rs1_data; mn.d2 = id_rs2_data;
      mn.a1 = id_rs1_addr; mn.a2 = id_rs2_addr; mn.rd = id_rd_addr;
      mn.op = id_alu_control; mn.sa = id_alu_src_a; mn.sb = id_alu_src_b;
      mn.rw = id_reg_write; mn.mr = id_mem_read; mn.mw = id_mem_write;
    end
  endtask

  logic [31:0] held_a;
  logic [3:0]  held_op;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_alu_control", {28'd0, alu_control}, 32'd0);
    chk("reset_alu_ab", alu_a | alu_b, 32'd0);
    chk("reset_ctrl", {24'd0, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    #9 rst_n = 1'b1;

    // ADD x3 = x1 + x2
    id_valid = 1; id_rs1_addr = 1; id_rs2_addr = 2; id_rs1_used = 1; id_rs2_used = 1;
    id_rs1_data = 5; id_rs2_data = 7; id_rd_addr = 3; id_reg_write = 1;
    id_alu_control = AluAdd;
    step();
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_alu_control", {28'd0, alu_control}, {28'd0, AluAdd});
    chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);

    // Forwarding priority with EX holding rs1=x1
    ext_stall = 1;
    exmem_rd_addr = 1; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd_addr = 1; memwb_reg_write = 1; memwb_result = 32'h20;
    #1 chk("fwd_exmem_prio", alu_a, 32'h10);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", alu_a, 32'h20);
    memwb_reg_write = 0;

    // x0 is never forwarded
    ext_stall = 0;
    id_rs1_addr = 0; id_rs1_data = 0;
    step();
    exmem_rd_addr = 0; exmem_reg_write = 1; exmem_result = 32'hFFFF_FFFF;
    #1 chk("fwd_x0_blocked", alu_a, 32'd0);
    exmem_reg_write = 0;

    // Load x4 followed by SUB reading x4
    id_rs1_addr = 1; id_rd_addr = 4; id_mem_read = 1; id_alu_control = AluAdd;
    step();
    id_mem_read = 0; id_rs1_addr = 4; id_rd_addr = 5; id_alu_control = AluSub;
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_id_ready", {31'd0, id_ready}, 32'd0);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_ctrl", {28'd0, alu_control}, 32'd0);
    step();
    chk("lu_sub_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_sub_op", {28'd0, alu_control}, {28'd0, AluSub});

    // flush beats ext_stall
    flush = 1; ext_stall = 1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_enables", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

    // ext_stall alone holds everything
    flush = 0; ext_stall = 0; id_rs1_addr = 1; id_rs1_data = 32'h1234; id_mem_write = 1;
    step();
    held_a = alu_a; held_op = alu_control;
    chk("pre_stall_a", held_a, 32'h1234);
    ext_stall = 1; id_rs1_data = 32'h9999; id_alu_control = AluAdd; id_mem_write = 0;
    step();
    chk("stall_hold_a", alu_a, 32'h1234);
    chk("stall_hold_op", {28'd0, alu_control}, {28'd0, AluSub});
    chk("stall_hold_ctrl", {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
        32'b1101);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_op", {28'd0, alu_control}, 32'd0);
    chk("async_rst_rw", {31'd0, ex_reg_write}, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m = '{default: 0};

    // Random traffic; decode re-presents its instruction while not accepted.
    exp_ready = 1;
    for (int i = 0; i < 3000; i++) begin
      if (exp_ready || flush) gen_id();
      flush     = ($urandom_range(0, 11) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      exmem_rd_addr   = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_result    = $urandom;
      memwb_rd_addr   = 5'($urandom_range(0, 3));
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_result    = $urandom;
      #2;
      check_model();
      step();
      m = mn;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
